// File: rtl/canvas_i2c_pkg.sv
// Shared definitions for the canvas cursor/status I2C read master.
package canvas_i2c_pkg;

  localparam logic [6:0]  I2C_ADDR_CANVAS = 7'h64;
  localparam int unsigned READ_BYTES      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_READ,
    ST_MACK,
    ST_STOP,
    ST_DONE
  } state_t;

  // Field positions inside the status byte
  localparam int unsigned STATUS_UP         = 7;
  localparam int unsigned STATUS_DOWN       = 6;
  localparam int unsigned STATUS_LEFT       = 5;
  localparam int unsigned STATUS_RIGHT      = 4;
  localparam int unsigned STATUS_BRUSH      = 3;
  localparam int unsigned STATUS_COLOUR_MSB = 2;
  localparam int unsigned STATUS_COLOUR_LSB = 0;

endpackage

// File: rtl/canvas_i2c_master_qtick.sv
// Quarter-bit tick divider; freezes while the responder stretches SCL.
module i2c_qtick_gen #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hold,
  output logic qtick
);

  localparam int unsigned W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign qtick = run & ~hold & (cnt == LAST);

endmodule

// File: rtl/canvas_i2c_master.sv
// I2C read master: fetches x, y and status bytes from the canvas responder
// and publishes them as one atomic snapshot.
module canvas_i2c_master
  import canvas_i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 250,
  parameter logic [6:0]  I2C_ADDR = I2C_ADDR_CANVAS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic [7:0] status_out
);

  localparam logic [7:0] ADDR_BYTE = {I2C_ADDR, 1'b1};

  state_t     state;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] shreg;
  logic [7:0] x_sh, y_sh, s_sh;
  logic       nack;
  logic [1:0] scl_sync, sda_sync, rel_d;
  logic       scl_s, sda_s, hold, run, qtick;
  logic       scl_want, sda_want, sda_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      rel_d    <= '1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      rel_d    <= {rel_d[0], ~scl_oe};
    end
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  // Stretch is only trusted once the synchronizer has had time to see our
  // own release, otherwise every bit would lose two cycles to sync latency.
  assign hold = ~scl_oe & (&rel_d) & ~scl_s;
  assign run  = (state != ST_IDLE) && (state != ST_DONE);

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .hold  (hold),
    .qtick (qtick)
  );

  always_comb begin
    scl_want = 1'b0;
    sda_want = 1'b0;
    case (state)
      ST_START:    sda_want = q[1];
      ST_ADDR: begin
        scl_want = ~q[1];
        sda_want = ~ADDR_BYTE[~bit_cnt];
      end
      ST_ADDR_ACK,
      ST_READ:     scl_want = ~q[1];
      ST_MACK: begin
        scl_want = ~q[1];
        sda_want = (byte_cnt != 2'(READ_BYTES - 1));
      end
      ST_STOP: begin
        scl_want = ~q[1];
        sda_want = (q != 2'd3);
      end
      default: ;
    endcase
  end

  // SDA follows only after SCL is already low, so data never moves while SCL is high.
  assign sda_hold = (q == 2'd0) && !scl_oe && (state != ST_START);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      q          <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      x_sh       <= '0;
      y_sh       <= '0;
      s_sh       <= '0;
      nack       <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_error  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      status_out <= '0;
    end else begin
      done   <= 1'b0;
      scl_oe <= scl_want;
      if (!sda_hold) sda_oe <= sda_want;
      case (state)
        ST_IDLE: begin
          q <= '0;
          if (start) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_DONE: begin
          q <= '0;
          if (start) begin
            state <= ST_START;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: if (qtick) begin
          q <= q + 2'd1;
          if (q == 2'd2) begin
            if (state == ST_ADDR_ACK) nack  <= sda_s;
            if (state == ST_READ)     shreg <= {shreg[6:0], sda_s};
          end
          if (q == 2'd3) begin
            case (state)
              ST_START: begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
              end
              ST_ADDR: begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state <= ST_ADDR_ACK;
              end
              ST_ADDR_ACK: begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                state    <= nack ? ST_STOP : ST_READ;
              end
              ST_READ: begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  case (byte_cnt)
                    2'd0:    x_sh <= shreg;
                    2'd1:    y_sh <= shreg;
                    default: s_sh <= shreg;
                  endcase
                  state <= ST_MACK;
                end
              end
              ST_MACK: begin
                if (byte_cnt == 2'(READ_BYTES - 1)) begin
                  state <= ST_STOP;
                end else begin
                  byte_cnt <= byte_cnt + 2'd1;
                  state    <= ST_READ;
                end
              end
              ST_STOP: begin
                state <= ST_DONE;
                done  <= 1'b1;
                if (nack) begin
                  ack_error <= 1'b1;
                end else begin
                  ack_error  <= 1'b0;
                  x_out      <= x_sh;
                  y_out      <= y_sh;
                  status_out <= s_sh;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_i2c_master.sv
// Directed bench: open-drain bus plus a canvas responder model at 0x64.
module tb_canvas_i2c_master;
  import canvas_i2c_pkg::*;

  localparam int CDIV    = 4;
  localparam int LIMIT   = 3000;
  localparam int STRETCH = 104;

  logic clk = 1'b0;
  logic rst_n, start;
  logic scl_oe, sda_oe, busy, done, ack_error;
  logic [7:0] x_out, y_out, status_out;
  logic slv_scl_low = 1'b0, slv_sda_low = 1'b0;
  logic scl_line, sda_line;

  assign scl_line = ~(scl_oe | slv_scl_low);
  assign sda_line = ~(sda_oe | slv_sda_low);

  always #5 clk = ~clk;

  canvas_i2c_master #(.CLK_DIV(CDIV), .I2C_ADDR(7'h64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .scl_in(scl_line), .sda_in(sda_line),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy), .done(done),
    .ack_error(ack_error), .x_out(x_out), .y_out(y_out), .status_out(status_out)
  );

  // Responder configuration, written only by the stimulus process
  logic       present = 1'b1;
  logic       stretch_en = 1'b0;
  logic [7:0] resp [3];

  typedef enum {P_IDLE, P_ADDR, P_ACK, P_TX, P_MACK} phase_t;
  phase_t     phase;
  int         bitc, bytec, str_cnt;
  int         scl_rises = 0, start_evt = 0, stop_evt = 0;
  logic [7:0] sh, addr_seen;
  logic [2:0] mack_log;
  logic       scl_prev = 1'b1, sda_prev = 1'b1, str_arm, stretched;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase <= P_IDLE; slv_sda_low <= 1'b0; slv_scl_low <= 1'b0;
      str_arm <= 1'b0; stretched <= 1'b0; str_cnt <= 0;
      scl_prev <= 1'b1; sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_line;
      sda_prev <= sda_line;
      if (scl_line && !scl_prev) scl_rises <= scl_rises + 1;
      if (slv_scl_low) begin
        if (!scl_oe) str_cnt <= str_cnt + 1;
        if (!scl_oe && str_cnt == STRETCH - 1) slv_scl_low <= 1'b0;
      end
      if (scl_line && scl_prev && sda_prev && !sda_line) begin
        start_evt <= start_evt + 1;
        phase <= P_ADDR; bitc <= 0; sh <= '0; slv_sda_low <= 1'b0;
        addr_seen <= '0; mack_log <= 3'b010; stretched <= 1'b0;
      end else if (scl_line && scl_prev && !sda_prev && sda_line) begin
        stop_evt <= stop_evt + 1;
        phase <= P_IDLE; slv_sda_low <= 1'b0;
      end else if (scl_line && !scl_prev) begin
        case (phase)
          P_ADDR: begin
            sh <= {sh[6:0], sda_line};
            bitc <= bitc + 1;
            if (bitc == 7) addr_seen <= {sh[6:0], sda_line};
          end
          P_TX: begin
            bitc <= bitc + 1;
            if (stretch_en && !stretched && bytec == 2 && bitc == 3) str_arm <= 1'b1;
          end
          P_MACK: begin
            mack_log[bytec] <= sda_line;
            if (sda_line) phase <= P_IDLE;
            else begin bytec <= bytec + 1; bitc <= 0; phase <= P_TX; end
          end
          default: ;
        endcase
      end else if (!scl_line && scl_prev) begin
        if (str_arm) begin
          slv_scl_low <= 1'b1; str_arm <= 1'b0; stretched <= 1'b1; str_cnt <= 0;
        end
        case (phase)
          P_ADDR: if (bitc == 8) begin
            if (present && sh == 8'hC9) begin slv_sda_low <= 1'b1; phase <= P_ACK; end
            else phase <= P_IDLE;
          end
          P_ACK: begin
            phase <= P_TX; bytec <= 0; bitc <= 0; slv_sda_low <= ~resp[0][7];
          end
          P_TX: begin
            if (bitc == 8) begin slv_sda_low <= 1'b0; phase <= P_MACK; end
            else slv_sda_low <= ~resp[bytec][7 - bitc];
          end
          default: ;
        endcase
      end
    end
  end

  int total = 0, bad = 0;

  task automatic do_txn(output int cycles);
    @(negedge clk); start = 1'b1; cycles = 0;
    @(negedge clk); start = 1'b0; cycles = 1;
    while (done !== 1'b1 && cycles < LIMIT) begin
      @(negedge clk); cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({scl_oe, sda_oe, busy, done, ack_error} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {scl_oe, sda_oe, busy, done, ack_error});
    end
    total++; if ({x_out, y_out, status_out} !== 24'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=000000", {x_out, y_out, status_out});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, r0, s0, p0;
    resp[0] = 8'h12; resp[1] = 8'h34; resp[2] = 8'hA5; present = 1'b1;
    r0 = scl_rises; s0 = start_evt; p0 = stop_evt;
    do_txn(cyc);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_timeout got=%0d exp=done", cyc); end
    total++; if (cyc < 604 || cyc > 612) begin bad++; $display("FAIL basic_latency got=%0d exp=608+-4", cyc); end
    total++; if ({x_out, y_out, status_out} !== 24'h1234A5) begin
      bad++; $display("FAIL basic_data got=%h exp=1234a5", {x_out, y_out, status_out});
    end
    total++; if (ack_error !== 1'b0) begin bad++; $display("FAIL basic_ackerr got=%b exp=0", ack_error); end
    total++; if (addr_seen !== 8'hC9) begin bad++; $display("FAIL basic_addr got=%h exp=c9", addr_seen); end
    total++; if (status_out[STATUS_BRUSH] !== 1'b0 || status_out[STATUS_COLOUR_MSB:STATUS_COLOUR_LSB] !== 3'b101) begin
      bad++; $display("FAIL basic_fields got=%h exp=a5", status_out);
    end
    total++; if (scl_rises - r0 !== 37) begin bad++; $display("FAIL basic_scl_edges got=%0d exp=37", scl_rises - r0); end
    total++; if (start_evt - s0 !== 1 || stop_evt - p0 !== 1) begin
      bad++; $display("FAIL basic_startstop got=%0d/%0d exp=1/1", start_evt - s0, stop_evt - p0);
    end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL basic_done_pulse got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_ack_pattern;
    int cyc, s0, p0;
    resp[0] = 8'hFF; resp[1] = 8'h00; resp[2] = 8'h81;
    s0 = start_evt; p0 = stop_evt;
    do_txn(cyc);
    total++; if (mack_log !== 3'b100) begin bad++; $display("FAIL mack_slots got=%b exp=100", mack_log); end
    total++; if (start_evt - s0 !== 1 || stop_evt - p0 !== 1) begin
      bad++; $display("FAIL mack_sda_high got=%0d/%0d exp=1/1", start_evt - s0, stop_evt - p0);
    end
    total++; if ({x_out, y_out, status_out} !== 24'hFF0081) begin
      bad++; $display("FAIL mack_data got=%h exp=ff0081", {x_out, y_out, status_out});
    end
  endtask

  task automatic test_nack;
    int cyc, p0;
    present = 1'b0; p0 = stop_evt;
    do_txn(cyc);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL nack_done got=%b exp=1", done); end
    total++; if (ack_error !== 1'b1) begin bad++; $display("FAIL nack_flag got=%b exp=1", ack_error); end
    total++; if ({x_out, y_out, status_out} !== 24'hFF0081) begin
      bad++; $display("FAIL nack_keep got=%h exp=ff0081", {x_out, y_out, status_out});
    end
    total++; if (stop_evt - p0 !== 1) begin bad++; $display("FAIL nack_stop got=%0d exp=1", stop_evt - p0); end
    present = 1'b1; resp[0] = 8'h56; resp[1] = 8'h78; resp[2] = 8'h0F;
    do_txn(cyc);
    total++; if (ack_error !== 1'b0) begin bad++; $display("FAIL nack_clear got=%b exp=0", ack_error); end
    total++; if ({x_out, y_out, status_out} !== 24'h56780F) begin
      bad++; $display("FAIL nack_reread got=%h exp=56780f", {x_out, y_out, status_out});
    end
  endtask

  task automatic test_stretch;
    int cyc, r0;
    resp[0] = 8'h9A; resp[1] = 8'hBC; resp[2] = 8'hDE; stretch_en = 1'b1;
    r0 = scl_rises;
    do_txn(cyc);
    stretch_en = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stretch_timeout got=%0d exp=done", cyc); end
    total++; if (cyc < 709 || cyc > 609 + STRETCH + 8) begin
      bad++; $display("FAIL stretch_latency got=%0d exp=709..%0d", cyc, 609 + STRETCH + 8);
    end
    total++; if ({x_out, y_out, status_out} !== 24'h9ABCDE) begin
      bad++; $display("FAIL stretch_data got=%h exp=9abcde", {x_out, y_out, status_out});
    end
    total++; if (scl_rises - r0 !== 37) begin bad++; $display("FAIL stretch_scl_edges got=%0d exp=37", scl_rises - r0); end
  endtask

  task automatic test_reset_mid;
    int cyc, w;
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!(phase == P_TX && bytec == 1 && bitc == 3) && w < LIMIT) begin @(negedge clk); w++; end
    total++; if (w >= LIMIT) begin bad++; $display("FAIL midrst_reach got=%0d exp=<%0d", w, LIMIT); end
    rst_n = 1'b0;
    #1;
    total++; if ({scl_oe, sda_oe, busy, done, ack_error} !== 5'b0) begin
      bad++; $display("FAIL midrst_lines got=%b exp=00000", {scl_oe, sda_oe, busy, done, ack_error});
    end
    total++; if ({x_out, y_out, status_out} !== 24'h0) begin
      bad++; $display("FAIL midrst_data got=%h exp=000000", {x_out, y_out, status_out});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_txn(cyc);
    total++; if ({done, x_out, y_out, status_out} !== {1'b1, 24'h112233}) begin
      bad++; $display("FAIL midrst_after got=%b/%h exp=1/112233", done, {x_out, y_out, status_out});
    end
  endtask

  task automatic test_back_to_back;
    int n_done, w;
    resp[0] = 8'h44; resp[1] = 8'h55; resp[2] = 8'h66;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 1400; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      start = busy && !done && (c == 40 || c == 300 || c == 550);
    end
    start = 1'b0;
    total++; if (n_done !== 1) begin bad++; $display("FAIL busy_ignore got=%0d exp=1", n_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b exp=0", busy); end
    // second part: a start issued during the DONE cycle must chain
    resp[0] = 8'h77; resp[1] = 8'h88; resp[2] = 8'h99;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (done !== 1'b1 && w < LIMIT) begin @(negedge clk); w++; end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL chain_accept got=%b exp=1", busy); end
    w = 0;
    while (done !== 1'b1 && w < LIMIT) begin @(negedge clk); w++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL chain_done got=%0d exp=done", w); end
    total++; if ({x_out, y_out, status_out} !== 24'h778899) begin
      bad++; $display("FAIL chain_data got=%h exp=778899", {x_out, y_out, status_out});
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ack_pattern;
    test_nack;
    test_stretch;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/canvas_i2c_master.md
Name: canvas_i2c_master

Overview:
- Host-side I2C controller that reads the canvas cursor/status registers from the on-chip I2C responder at address 0x64.
- One read transaction delivers three bytes in order: x_pos, y_pos, status.
- Used by the companion display/host board and as the active bus agent in the canvas test bench.
- Drives open-drain SCL/SDA through output-enable lines, supports responder clock stretching, and presents the three bytes as one atomic register snapshot.

Parameters:
- CLK_DIV, 250: clk cycles per quarter SCL bit period; minimum 2. At 50 MHz this gives 50 kHz SCL.
- I2C_ADDR, 7'h64: 7-bit responder address.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to run one read transaction
- scl_in  input  1  SCL pad sense
- sda_in  input  1  SDA pad sense
- scl_oe  output  1  1 = pull SCL low; 0 = release
- sda_oe  output  1  1 = pull SDA low; 0 = release
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at transaction end, on success or error
- ack_error  output  1  sticky flag: last transaction got a NACK on the address byte
- x_out  output  8  last good x byte
- y_out  output  8  last good y byte
- status_out  output  8  last good status byte (bits [7:4] up/down/left/right, bit 3 brush_mode, bits [2:0] colour)

Behaviour:
- Reset (asynchronous):
  - scl_oe=0, sda_oe=0, busy=0, done=0, ack_error=0.
  - x_out, y_out, status_out = 0; FSM in IDLE.
  - Reset mid-transaction releases both lines immediately and discards partial data.
- Input sampling: scl_in and sda_in each pass through a 2-flop synchronizer before any use.
- Tick generator:
  - Counter 0..CLK_DIV-1 produces a one-cycle qtick. It is held at 0 while in IDLE.
  - Every bit is 4 quarters:
    - Q0: SCL low; drive next SDA value.
    - Q1: SCL low.
    - Q2: SCL released.
    - Q3: SCL released.
  - Stretching: while SCL is released and synchronized scl_in is 0, the counter freezes. The Q2 count starts only after scl_in reads 1.
  - SDA is sampled at the end of Q2.
- FSM states: IDLE, START, ADDR, ADDR_ACK, READ, MACK, STOP, DONE.
  - IDLE: busy=0. On start=1, go to START and set busy=1 in the next cycle. start is ignored while busy.
  - START (4 quarters):
    - Q0/Q1: both lines released.
    - Q2/Q3: sda_oe=1 with SCL still released. This is the start condition.
    - Then go to ADDR.
  - ADDR: 8 bits, MSB first, {I2C_ADDR, 1'b1}. A bit value of 0 means sda_oe=1.
  - ADDR_ACK: SDA released.
    - Sampled 0: go to READ with byte counter=0.
    - Sampled 1: set ack_error=1 and go to STOP. Data registers are left unchanged.
  - READ: SDA released; shift in 8 bits, MSB first, into shadow byte[byte counter].
  - MACK:
    - Byte counter 0 or 1: drive ACK (sda_oe=1), increment the counter, return to READ.
    - Byte counter 2: NACK (released), go to STOP.
  - STOP (4 quarters):
    - Q0/Q1: SCL low, sda_oe=1.
    - Q2: SCL released.
    - Q3: sda_oe=0. This is the stop condition.
  - DONE (1 cycle):
    - done=1; busy=0 from the next cycle.
    - On success, x_out/y_out/status_out are loaded from the shadows in this same cycle, and ack_error is cleared.
- Outputs never change except in the DONE cycle, so no torn snapshot is visible.
- Latency: 38 bits × 4 × CLK_DIV cycles (+2 for sync/DONE) with no stretching. For CLK_DIV=4 this is 608 ±4 cycles from start to done.
- start asserted in the DONE cycle is accepted.
- There is no timeout: an SCL held low indefinitely stalls the FSM until reset.

Decomposition:
- Shared package canvas_i2c_pkg:
  - I2C_ADDR_CANVAS = 7'h64
  - READ_BYTES = 3
  - FSM state enum
  - status bit-index constants
- Natural sub-module: i2c_qtick_gen, containing the divider plus stretch freeze. Inputs are clk, rst_n, run, hold; output is qtick.

Test Plan:
- Basic read, CLK_DIV=4, with a responder model at 0x64 returning 0x12, 0x34, 0xA5:
  - done rises 608 ±4 cycles after start.
  - Outputs read x_out=0x12, y_out=0x34, status_out=0xA5; ack_error=0.
  - Address byte observed on the bus is 0xC9.
- Address NACK, no responder present:
  - ack_error=1 and done pulses.
  - Outputs keep their previous values.
  - A STOP condition is observed, with SDA rising while SCL is high.
  - A following good read clears ack_error.
- Clock stretch: responder holds SCL low for 100 cycles after the 4th data bit of byte 2.
  - done is delayed by ≥100 cycles.
  - Data is still correct and no glitch edges appear on SCL.
- Master ACK pattern:
  - SDA is low in the ACK slots after bytes 0 and 1 and released after byte 2.
  - SDA changes only while SCL is low, except at START and STOP.
- Reset mid-READ, asserted in byte 1:
  - scl_oe=sda_oe=0 in the same cycle.
  - All outputs are 0 and busy=0.
  - A new start completes normally.
- start pulses while busy:
  - Exactly one transaction occurs (one done pulse).
  - A start in the DONE cycle begins a second transaction.
